btn_move_conditioner: RTL and testbench

BTN_MOVE_CONDITIONER -- requirements
Module: btn_move_conditioner

---
 rtl/ee354_input_pkg.sv | 27 ++
 rtl/btn_move_conditioner_btn_channel.sv | 99 +++++++++
 rtl/btn_move_conditioner.sv | 142 ++++++++++++++
 tb/tb_btn_move_conditioner.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ee354_input_pkg.sv
// Shared defaults and helpers for the push-button input path.
// Reused by the game state machine for event index widths.
package ee354_input_pkg;

    localparam int N_BTN_DEF     = 4;
    localparam int DB_CYCLES_DEF = 1000000;
    localparam int DIV_W_DEF     = 28;
    localparam int RPT_DLY_DEF   = 24;
    localparam int RPT_RATE_DEF  = 6;

    // Per-channel request raised toward the arbiter.
    typedef struct packed {
        logic press;
        logic rpt;
    } btn_req_t;

    // Event index width; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_move_conditioner_btn_channel.sv
// One button channel: synchronizer, debounce and auto-repeat.
// Emits a press pulse on the accepted rising level and repeat pulses.
module btn_channel
    import ee354_input_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int RPT_DLY   = RPT_DLY_DEF,
    parameter int RPT_RATE  = RPT_RATE_DEF
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  logic     raw_i,
    input  logic     tick_i,
    input  logic     rpt_en_i,
    output logic     level_o,
    output btn_req_t req_o
);

    localparam int DW   = cnt_w(DB_CYCLES);
    localparam int RMAX = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
    localparam int RW   = cnt_w(RMAX);

    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(RPT_DLY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(RPT_RATE - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [DW-1:0] db_q, db_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          phase_q, phase_d;
    logic          flip;
    logic          fire;

    // Two-flop synchronizer for the asynchronous button pin.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count cycles of disagreement; accept the new level once it held.
    always_comb begin
        db_d    = '0;
        level_d = level_q;
        flip    = 1'b0;
        if (sync2_q != level_q) begin
            if (db_q == DB_LAST) begin
                flip    = 1'b1;
                level_d = sync2_q;
            end else begin
                db_d = db_q + DW'(1);
            end
        end
    end

    // Count ticks while held: first repeat after RPT_DLY, then every RPT_RATE.
    always_comb begin
        rpt_d   = rpt_q;
        phase_d = phase_q;
        fire    = 1'b0;
        if (!level_q || !rpt_en_i) begin
            rpt_d   = '0;
            phase_d = 1'b0;
        end else if (tick_i) begin
            if (rpt_q == (phase_q ? RATE_LAST : DLY_LAST)) begin
                fire    = 1'b1;
                rpt_d   = '0;
                phase_d = 1'b1;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
        end
    end

    // Debounce and repeat state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            level_q <= 1'b0;
            db_q    <= '0;
            rpt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            level_q <= level_d;
            db_q    <= db_d;
            rpt_q   <= rpt_d;
            phase_q <= phase_d;
        end
    end

    assign level_o     = level_q;
    assign req_o.press = flip & sync2_q;
    assign req_o.rpt   = fire;

endmodule

// File: rtl/btn_move_conditioner.sv
// Button conditioner top: move-rate divider, channels and event arbiter.
// Presents one event at a time; lowest channel index wins.
module btn_move_conditioner
    import ee354_input_pkg::*;
#(
    parameter  int N_BTN     = N_BTN_DEF,
    parameter  int DB_CYCLES = DB_CYCLES_DEF,
    parameter  int DIV_W     = DIV_W_DEF,
    parameter  int RPT_DLY   = RPT_DLY_DEF,
    parameter  int RPT_RATE  = RPT_RATE_DEF,
    localparam int IDX_W     = idx_w(N_BTN)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [4:0]       tap_sel,
    input  logic             rpt_en,
    input  logic             ack,
    output logic [DIV_W-1:0] div_cnt,
    output logic             tick,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_rpt,
    output logic             overrun
);

    localparam logic [4:0] TAP_MAX = 5'(DIV_W - 1);

    logic [DIV_W-1:0] div_q;
    logic             tick_q;
    logic [4:0]       tap;
    logic [DIV_W-1:0] edge_pat;
    logic [DIV_W-1:0] low_mask;
    logic             rise;

    btn_req_t         req [N_BTN];
    logic [N_BTN-1:0] req_press, req_rpt, req_any;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] clr, keep;
    logic             take, found;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rpt_q, rpt_d;
    logic             ovr_q, ovr_d;

    // Bit tap rises exactly when the low tap+1 bits read 1 followed by zeros.
    always_comb begin
        tap      = (tap_sel > TAP_MAX) ? TAP_MAX : tap_sel;
        edge_pat = DIV_W'(1) << tap;
        low_mask = (edge_pat << 1) - DIV_W'(1);
        rise     = (div_q & low_mask) == edge_pat;
    end

    // Free-running divider and registered move-rate strobe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_q + DIV_W'(1);
            tick_q <= rise;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .DB_CYCLES (DB_CYCLES),
            .RPT_DLY   (RPT_DLY),
            .RPT_RATE  (RPT_RATE)
        ) u_ch (
            .clk_i    (Clk),
            .rst_n_i  (Reset_n),
            .raw_i    (btn_raw[g]),
            .tick_i   (tick_q),
            .rpt_en_i (rpt_en),
            .level_o  (btn_level[g]),
            .req_o    (req[g])
        );
        assign req_press[g] = req[g].press;
        assign req_rpt[g]   = req[g].rpt;
    end

    // Pop the lowest pending channel when free; new requests set or merge.
    always_comb begin
        take    = !valid_q || ack;
        clr     = '0;
        found   = 1'b0;
        valid_d = valid_q;
        idx_d   = idx_q;
        rpt_d   = rpt_q;
        if (take) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (pend_q[i] && !found) begin
                    found  = 1'b1;
                    idx_d  = IDX_W'(i);
                    rpt_d  = !press_q[i];
                    clr[i] = 1'b1;
                end
            end
            valid_d = found;
        end
        keep    = pend_q & ~clr;
        req_any = req_press | req_rpt;
        pend_d  = keep | req_any;
        press_d = press_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (req_any[i]) begin
                press_d[i] = req_press[i] | (keep[i] & press_q[i]);
            end
        end
        ovr_d = ovr_q | (|(keep & req_any));
    end

    // Arbiter and presented-event registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_q  <= '0;
            press_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            rpt_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            press_q <= press_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            rpt_q   <= rpt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign div_cnt   = div_q;
    assign tick      = tick_q;
    assign evt_valid = valid_q;
    assign evt_idx   = idx_q;
    assign evt_rpt   = rpt_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_btn_move_conditioner.sv
// Bench for btn_move_conditioner with a small-parameter configuration.
// Behavioural model checked every cycle plus directed literal checks.
module tb_btn_move_conditioner;

    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int DLY  = 2;
    localparam int RATE = 2;
    localparam int DW   = 8;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic [N-1:0]  btn_raw = '0;
    logic [4:0]    tap_sel = 5'd1;
    logic          rpt_en = 1'b0;
    logic          ack = 1'b0;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [N-1:0]  btn_level;
    logic          evt_valid;
    logic [1:0]    evt_idx;
    logic          evt_rpt;
    logic          overrun;

    btn_move_conditioner #(
        .N_BTN     (N),
        .DB_CYCLES (DB),
        .DIV_W     (DW),
        .RPT_DLY   (DLY),
        .RPT_RATE  (RATE)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .btn_raw   (btn_raw),
        .tap_sel   (tap_sel),
        .rpt_en    (rpt_en),
        .ack       (ack),
        .div_cnt   (div_cnt),
        .tick      (tick),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_idx   (evt_idx),
        .evt_rpt   (evt_rpt),
        .overrun   (overrun)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_div;
    logic         m_tick;
    logic [N-1:0] m_lvl;
    logic [DB:0]  m_hist [N];
    int           m_n [N];
    logic [N-1:0] m_pend, m_press;
    logic         m_valid, m_rpt, m_ovr;
    int           m_idx;

    logic [N-1:0] t_rp, t_rr, t_keep, t_nlvl;
    logic         t_ntick, t_diff;
    int           t_tap;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_div = 0; m_tick = 1'b0; m_lvl = '0;
            m_pend = '0; m_press = '0;
            m_valid = 1'b0; m_rpt = 1'b0; m_ovr = 1'b0; m_idx = 0;
            for (int c = 0; c < N; c++) begin
                m_hist[c] = '0;
                m_n[c] = 0;
            end
        end else begin
            t_tap = (tap_sel > 5'd7) ? 7 : int'(tap_sel);
            t_ntick = (((m_div >> t_tap) & 1) == 1) &&
                      (((((m_div + 255) % 256) >> t_tap) & 1) == 0);
            for (int c = 0; c < N; c++) begin
                // level flips once the last DB synchronized samples all disagree
                t_diff = 1'b1;
                for (int k = 1; k <= DB; k++)
                    if (m_hist[c][k] == m_lvl[c]) t_diff = 1'b0;
                t_nlvl[c] = t_diff ? ~m_lvl[c] : m_lvl[c];
                t_rp[c] = t_diff && !m_lvl[c];
                t_rr[c] = 1'b0;
                if (!m_lvl[c] || !rpt_en) begin
                    m_n[c] = 0;
                end else if (m_tick) begin
                    m_n[c]++;
                    if (m_n[c] == DLY ||
                        (m_n[c] > DLY && (m_n[c] - DLY) % RATE == 0))
                        t_rr[c] = 1'b1;
                end
            end
            t_keep = m_pend;
            if (!m_valid || ack) begin
                m_valid = 1'b0;
                for (int c = 0; c < N; c++) begin
                    if (t_keep[c] && !m_valid) begin
                        m_valid = 1'b1;
                        m_idx = c;
                        m_rpt = !m_press[c];
                        t_keep[c] = 1'b0;
                    end
                end
            end
            for (int c = 0; c < N; c++) begin
                if (t_rp[c] || t_rr[c]) begin
                    if (t_keep[c]) begin
                        m_ovr = 1'b1;
                        m_press[c] = m_press[c] | t_rp[c];
                    end else begin
                        m_press[c] = t_rp[c];
                    end
                end
            end
            m_pend = t_keep | t_rp | t_rr;
            for (int c = 0; c < N; c++)
                m_hist[c] = {m_hist[c][DB-1:0], btn_raw[c]};
            m_lvl  = t_nlvl;
            m_div  = (m_div + 1) % 256;
            m_tick = t_ntick;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge Clk) begin
        chk("div_cnt", 32'(div_cnt), m_div);
        chk("tick", 32'(tick), 32'(m_tick));
        chk("btn_level", 32'(btn_level), 32'(m_lvl));
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (m_valid && evt_valid) begin
            chk("evt_idx", 32'(evt_idx), m_idx);
            chk("evt_rpt", 32'(evt_rpt), 32'(m_rpt));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic measure(output int per);
        int k;
        per = -1;
        k = 0;
        while (!tick && k < 600) begin step(1); k++; end
        if (tick) begin
            k = 0;
            do begin step(1); k++; end while (!tick && k < 600);
            if (tick) per = k;
        end
    endtask

    int ntick, nrep, per, nev, kk;
    int rep_at [3];

    initial begin
        step(2);
        chk("rst_div", 32'(div_cnt), 0);
        chk("rst_level", 32'(btn_level), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_ovr", 32'(overrun), 0);
        Reset_n = 1'b1;
        step(3);

        // accept latency and first event
        btn_raw[0] = 1'b1;
        step(5);
        chk("t1_lvl_at5", 32'(btn_level[0]), 0);
        step(1);
        chk("t1_lvl_at6", 32'(btn_level[0]), 1);
        chk("t1_valid_at6", 32'(evt_valid), 0);
        step(1);
        chk("t1_valid_at7", 32'(evt_valid), 1);
        chk("t1_idx", 32'(evt_idx), 0);
        chk("t1_rpt", 32'(evt_rpt), 0);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("t1_drained", 32'(evt_valid), 0);

        // short glitch rejected
        btn_raw[2] = 1'b1;
        step(3);
        btn_raw[2] = 1'b0;
        step(10);
        chk("t2_lvl2", 32'(btn_level[2]), 0);
        chk("t2_noevt", 32'(evt_valid), 0);

        // simultaneous presses, stall then ack pulse
        btn_raw[1] = 1'b1;
        btn_raw[3] = 1'b1;
        step(6);
        chk("t3_lvl", 32'(btn_level & 4'b1010), 32'hA);
        step(1);
        chk("t3_valid", 32'(evt_valid), 1);
        chk("t3_idx1", 32'(evt_idx), 1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t3_hold", 32'({evt_valid, evt_idx}), 32'h5);
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("t3_next", 32'({evt_valid, evt_idx, evt_rpt}), 32'hE);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("t3_empty", 32'(evt_valid), 0);

        // auto-repeat schedule
        btn_raw = '0;
        step(10);
        chk("t4_released", 32'(btn_level), 0);
        rpt_en = 1'b1;
        ack = 1'b1;
        btn_raw[0] = 1'b1;
        ntick = 0;
        nrep = 0;
        rep_at = '{0, 0, 0};
        for (int i = 0; i < 120 && nrep < 3; i++) begin
            step(1);
            if (tick && btn_level[0]) ntick++;
            if (evt_valid && evt_rpt && evt_idx == 2'd0) begin
                rep_at[nrep] = ntick;
                nrep++;
            end
        end
        chk("t4_nrep", nrep, 3);
        chk("t4_rep0", rep_at[0], 2);
        chk("t4_rep1", rep_at[1], 4);
        chk("t4_rep2", rep_at[2], 6);

        // divider wrap and tick spacing
        rpt_en = 1'b0;
        step(2);
        kk = 0;
        while (div_cnt != 8'd255 && kk < 300) begin step(1); kk++; end
        chk("t5_at255", 32'(div_cnt), 255);
        step(1);
        chk("t5_wrap", 32'(div_cnt), 0);
        measure(per);
        chk("t5_per_tap1", per, 4);
        tap_sel = 5'd20;
        step(2);
        measure(per);
        chk("t5_per_clamp", per, 256);

        // overrun by merged repeats, then reset mid-event
        tap_sel = 5'd1;
        ack = 1'b0;
        rpt_en = 1'b1;
        kk = 0;
        while (!overrun && kk < 100) begin step(1); kk++; end
        chk("t6_ovr", 32'(overrun), 1);
        chk("t6_valid", 32'({evt_valid, evt_rpt}), 32'h3);
        Reset_n = 1'b0;
        #1;
        chk("t6_rst_div", 32'(div_cnt), 0);
        chk("t6_rst_tick", 32'(tick), 0);
        chk("t6_rst_lvl", 32'(btn_level), 0);
        chk("t6_rst_evt", 32'({evt_valid, evt_idx, evt_rpt}), 0);
        chk("t6_rst_ovr", 32'(overrun), 0);
        rpt_en = 1'b0;
        ack = 1'b1;
        step(2);
        Reset_n = 1'b1;
        step(5);
        chk("t6_lvl_at5", 32'(btn_level[0]), 0);
        step(1);
        chk("t6_lvl_at6", 32'(btn_level[0]), 1);
        step(1);
        chk("t6_press", 32'({evt_valid, evt_idx, evt_rpt}), 32'h8);
        nev = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (evt_valid) nev++;
        end
        chk("t6_nodup", nev, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures",
                 n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
